// File: rtl/branch_target_table.sv
// branch_target_table: programmable, valid-tagged label -> next-PC table.
// After reset or flush the valid vector is cleared one entry per cycle (INIT);
// in RUN the table accepts one write and one lookup per cycle, and each
// lookup result is returned with a registered one-cycle latency.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               pulse: invalidate all entries (re-run init sweep)
//   ready               table initialised (state RUN)
//   wr_en/label/target  write port, honoured only while ready
//   rd_req/label        lookup port, honoured only while ready
//   rd_ack/next_pc/hit  registered lookup result; next_pc/hit are 0 unless rd_ack
//
// Optional feature: define BTT_BYPASS_EN to forward a same-cycle write to a
// lookup of the same label; otherwise such a collision reads the prior contents.
module branch_target_table #(
  parameter int unsigned LW    = 8,
  parameter int unsigned PW    = 12,
  parameter int unsigned DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  output logic          ready,
  input  logic          wr_en,
  input  logic [LW-1:0] wr_label,
  input  logic [PW-1:0] wr_target,
  input  logic          rd_req,
  input  logic [LW-1:0] rd_label,
  output logic          rd_ack,
  output logic [PW-1:0] next_pc,
  output logic          hit
);

  localparam int unsigned IW       = $clog2(DEPTH);
  // DEPTH held one bit wider than a label so DEPTH == 2^LW compares correctly
  localparam logic [LW:0] DEPTH_L  = (LW+1)'(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;

  logic [PW-1:0]    r_target [DEPTH];
  logic [DEPTH-1:0] r_valid;

  logic          r_ready, r_rd_ack, r_hit;
  logic [PW-1:0] r_next_pc;
  logic          w_ready_nxt, w_rd_ack_nxt, w_hit_nxt;
  logic [PW-1:0] w_next_pc_nxt;

  logic          w_wr_in_range, w_rd_in_range;
  logic          w_wr_ok, w_rd_ok, w_clear;
  logic [IW-1:0] w_wr_idx, w_rd_idx;

  // Range checks use the full label so out-of-range labels never alias
  assign w_wr_in_range = ({1'b0, wr_label} < DEPTH_L);
  assign w_rd_in_range = ({1'b0, rd_label} < DEPTH_L);
  assign w_wr_idx      = wr_label[IW-1:0];
  assign w_rd_idx      = rd_label[IW-1:0];

  // Next-state, accept qualification and next output values
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_clear       = 1'b0;
    w_wr_ok       = 1'b0;
    w_rd_ok       = 1'b0;
    w_hit_nxt     = 1'b0;
    w_next_pc_nxt = '0;

    case (r_state)
      S_INIT: begin
        w_clear = 1'b1;
        if (flush) begin
          w_idx_nxt = '0;
        end else if (r_idx == LAST_IDX) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end
      S_RUN: begin
        // flush wins over any same-cycle write or lookup
        if (flush) begin
          w_state_nxt = S_INIT;
          w_idx_nxt   = '0;
        end else begin
          w_wr_ok = wr_en && w_wr_in_range;
          w_rd_ok = rd_req;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_idx_nxt   = '0;
      end
    endcase

    w_ready_nxt  = (w_state_nxt == S_RUN);
    w_rd_ack_nxt = w_rd_ok;

    // Array read sees pre-write contents (read-before-write)
    if (w_rd_ok && w_rd_in_range && r_valid[w_rd_idx]) begin
      w_hit_nxt     = 1'b1;
      w_next_pc_nxt = r_target[w_rd_idx];
    end
`ifdef BTT_BYPASS_EN
    // Forward a same-cycle write to a lookup of the same label
    if (w_rd_ok && w_wr_ok && (wr_label == rd_label)) begin
      w_hit_nxt     = 1'b1;
      w_next_pc_nxt = wr_target;
    end
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_INIT;
      r_idx     <= '0;
      r_ready   <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_hit     <= 1'b0;
      r_next_pc <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_ready   <= w_ready_nxt;
      r_rd_ack  <= w_rd_ack_nxt;
      r_hit     <= w_hit_nxt;
      r_next_pc <= w_next_pc_nxt;
    end
  end

  // Target storage; contents of invalid entries are don't-care
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_ok) begin
      r_target[w_wr_idx] <= wr_target;
    end
  end

  // Valid vector: cleared only by the init sweep, set by accepted writes
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_clear) begin
        r_valid[r_idx] <= 1'b0;
      end else if (w_wr_ok) begin
        r_valid[w_wr_idx] <= 1'b1;
      end
    end
  end

  assign ready   = r_ready;
  assign rd_ack  = r_rd_ack;
  assign next_pc = r_next_pc;
  assign hit     = r_hit;

endmodule

// File: tb/tb_branch_target_table.sv
// Testbench for branch_target_table: directed scenarios plus randomized
// traffic, checked against a table-level reference model via a scoreboard.
module tb_branch_target_table;

  localparam int unsigned LW    = 8;
  localparam int unsigned PW    = 12;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          ready;
  logic          wr_en;
  logic [LW-1:0] wr_label;
  logic [PW-1:0] wr_target;
  logic          rd_req;
  logic [LW-1:0] rd_label;
  logic          rd_ack;
  logic [PW-1:0] next_pc;
  logic          hit;

  branch_target_table #(.LW(LW), .PW(PW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .ready     (ready),
    .wr_en     (wr_en),
    .wr_label  (wr_label),
    .wr_target (wr_target),
    .rd_req    (rd_req),
    .rd_label  (rd_label),
    .rd_ack    (rd_ack),
    .next_pc   (next_pc),
    .hit       (hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: table contents plus a cycles-until-ready counter
  bit            m_run;
  int            m_left;
  bit            m_valid  [DEPTH];
  logic [PW-1:0] m_target [DEPTH];

  typedef struct {
    int            due;
    bit            hit;
    logic [PW-1:0] pc;
  } exp_t;
  exp_t q[$];

  bit mon_on = 1'b0;

  // Monitor: pop and compare whenever the DUT acknowledges a lookup
  always @(negedge clk) begin
    if (mon_on) begin
      if (rd_ack) begin
        if (q.size() == 0) begin
          chk("spurious_ack", 32'(rd_ack), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_cycle", 32'(cyc), 32'(e.due));
          chk("hit", 32'(hit), 32'(e.hit));
          chk("next_pc", 32'(next_pc), 32'(e.pc));
        end
      end else begin
        chk("idle_hit", 32'(hit), 32'd0);
        chk("idle_pc", 32'(next_pc), 32'd0);
        while (q.size() > 0 && q[0].due <= cyc) begin
          chk("missed_ack", 32'(rd_ack), 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic idle_in();
    flush = 0; wr_en = 0; rd_req = 0;
    wr_label = '0; wr_target = '0; rd_label = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  // Apply current inputs at the next edge: update model, push expectation
  task automatic step();
    bit            e_hit;
    logic [PW-1:0] e_pc;
    if (!rst_n) begin
      m_run = 0; m_left = DEPTH; model_clear();
    end else if (!m_run) begin
      if (flush) m_left = DEPTH;
      else begin
        m_left--;
        if (m_left == 0) m_run = 1;
      end
    end else if (flush) begin
      m_run = 0; m_left = DEPTH; model_clear();
    end else begin
      if (rd_req) begin
        e_hit = 0; e_pc = '0;
        if (int'(rd_label) < DEPTH && m_valid[int'(rd_label)]) begin
          e_hit = 1; e_pc = m_target[int'(rd_label)];
        end
`ifdef BTT_BYPASS_EN
        if (wr_en && wr_label == rd_label && int'(wr_label) < DEPTH) begin
          e_hit = 1; e_pc = wr_target;
        end
`endif
        q.push_back('{due: cyc + 1, hit: e_hit, pc: e_pc});
      end
      if (wr_en && int'(wr_label) < DEPTH) begin
        m_valid[int'(wr_label)]  = 1'b1;
        m_target[int'(wr_label)] = wr_target;
      end
    end
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    chk("ready", 32'(ready), 32'(m_run));
  endtask

  task automatic do_write(input int lbl, input int tgt);
    idle_in(); wr_en = 1; wr_label = LW'(lbl); wr_target = PW'(tgt); step();
  endtask

  task automatic do_read(input int lbl);
    idle_in(); rd_req = 1; rd_label = LW'(lbl); step();
  endtask

  task automatic idle_steps(input int n);
    idle_in();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    step(); step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ack", 32'(rd_ack), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_pc", 32'(next_pc), 32'd0);

    // Init sweep; a lookup during INIT must not be acknowledged
    rst_n = 1;
    idle_steps(10);
    do_read(5);
    idle_steps(DEPTH - 11);
    chk("ready_after_init", 32'(ready), 32'd1);

    // Basic writes and back-to-back lookups
    do_write(2, 323);
    do_write(43, 445);
    do_read(2);
    do_read(43);
    do_read(7);
    idle_steps(1);

    // Out-of-range write dropped
    do_write(200, 99);
    do_read(200);
    do_read(2);
    do_read(8);
    idle_steps(1);

    // Same-cycle write/lookup collision
    do_write(10, 278);
    idle_in(); wr_en = 1; wr_label = 10; wr_target = 500; rd_req = 1; rd_label = 10; step();
    do_read(10);
    idle_steps(1);

    // Flush with a concurrent write; lookup just before still acknowledged
    for (int i = 0; i < 4; i++) do_write(i, 100 + i);
    do_read(1);
    idle_in(); flush = 1; wr_en = 1; wr_label = 4; wr_target = 1; step();
    idle_steps(DEPTH);
    for (int i = 0; i <= 4; i++) do_read(i);
    idle_steps(1);

    // Reset asserted at sweep index 30
    idle_in(); flush = 1; step();
    idle_steps(30);
    rst_n = 0; step();
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_ack", 32'(rd_ack), 32'd0);
    chk("midrst_pc", 32'(next_pc), 32'd0);
    rst_n = 1;
    idle_steps(DEPTH);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle_in();
      wr_en     = ($urandom_range(0, 1) == 1);
      rd_req    = ($urandom_range(0, 9) < 6);
      wr_label  = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 255)) : LW'($urandom_range(0, DEPTH - 1));
      rd_label  = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 255)) : LW'($urandom_range(0, DEPTH - 1));
      wr_target = PW'($urandom);
      if ($urandom_range(0, 7) == 0) rd_label = wr_label;
      flush     = ($urandom_range(0, 299) == 0);
      step();
    end
    idle_steps(3);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
